// File: rtl/gemm_pkg.sv
// gemm_pkg: shared defaults, drain FSM states and helpers for the GeMM result path.
package gemm_pkg;

    localparam int DefOutDataWidth = 32;
    localparam int DefRowPar       = 4;
    localparam int DefColPar       = 16;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        STR,
        FIN
    } drain_state_e;

    function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/gemm_tile_serializer.sv
// gemm_tile_serializer: holds one captured tile and walks its valid r/c extent row-major.
module gemm_tile_serializer
    import gemm_pkg::*;
#(
    parameter int OutDataWidth = DefOutDataWidth,
    parameter int RowPar       = DefRowPar,
    parameter int ColPar       = DefColPar,
    parameter int LimWidth     = 8
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                load_i,
    input  logic [RowPar*ColPar*OutDataWidth-1:0] tile_i,
    input  logic [LimWidth-1:0]                 vr_i,
    input  logic [LimWidth-1:0]                 vc_i,
    input  logic                                adv_i,
    output logic [OutDataWidth-1:0]             elem_o,
    output logic                                tile_end_o
);

    localparam int RW = RowPar > 1 ? $clog2(RowPar) : 1;
    localparam int CW = ColPar > 1 ? $clog2(ColPar) : 1;

    logic [RowPar*ColPar*OutDataWidth-1:0] tile_q;
    logic [RW-1:0]                         r_q, rmax_q;
    logic [CW-1:0]                         c_q, cmax_q;
    logic [OutDataWidth-1:0]               elems [RowPar][ColPar];

    // Element (0,0) lives in the MSB slice of the tile word.
    for (genvar i = 0; i < RowPar; i++) begin : g_r
        for (genvar j = 0; j < ColPar; j++) begin : g_c
            assign elems[i][j] = tile_q[(RowPar*ColPar-1-(i*ColPar+j))*OutDataWidth +: OutDataWidth];
        end
    end

    assign elem_o     = elems[r_q][c_q];
    assign tile_end_o = r_q == rmax_q && c_q == cmax_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tile_q <= '0;
            r_q    <= '0;
            c_q    <= '0;
            rmax_q <= '0;
            cmax_q <= '0;
        end else if (load_i) begin
            tile_q <= tile_i;
            r_q    <= '0;
            c_q    <= '0;
            rmax_q <= RW'(vr_i - LimWidth'(1));
            cmax_q <= CW'(vc_i - LimWidth'(1));
        end else if (adv_i) begin
            c_q <= c_q == cmax_q ? '0 : c_q + CW'(1);
            r_q <= c_q == cmax_q ? r_q + RW'(1) : r_q;
        end
    end

endmodule

// File: rtl/gemm_result_drain.sv
// gemm_result_drain: reads every result tile of C from SRAM and streams its valid
// elements one per beat, skipping edge-tile padding.
module gemm_result_drain
    import gemm_pkg::*;
#(
    parameter int OutDataWidth  = DefOutDataWidth,
    parameter int RowPar        = DefRowPar,
    parameter int ColPar        = DefColPar,
    parameter int AddrWidth     = 16,
    parameter int SizeAddrWidth = 8
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  start_i,
    input  logic [SizeAddrWidth-1:0]              M_size_i,
    input  logic [SizeAddrWidth-1:0]              N_size_i,
    input  logic [AddrWidth-1:0]                  base_addr_i,
    output logic [AddrWidth-1:0]                  sram_c_addr_o,
    output logic                                  sram_c_re_o,
    input  logic [RowPar*ColPar*OutDataWidth-1:0] sram_c_rdata_i,
    output logic [OutDataWidth-1:0]               out_data_o,
    output logic                                  out_valid_o,
    input  logic                                  out_ready_i,
    output logic                                  out_last_o,
    output logic                                  busy_o,
    output logic                                  done_o
);

    localparam int SW = SizeAddrWidth;
    localparam logic [SW-1:0] RP = SW'(RowPar);
    localparam logic [SW-1:0] CP = SW'(ColPar);

    drain_state_e         state_q, state_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [SW-1:0]        n_q, n_d, mt_q, mt_d, nt_q, nt_d, mtc_q, mtc_d, ntc_q, ntc_d;
    logic [SW-1:0]        row_rem_q, row_rem_d, col_rem_q, col_rem_d;
    logic [SW-1:0]        vr, vc;
    logic                 adv, tile_end, last_tile, row_end;

    // Remaining rows/cols from the current tile origin give the valid extent directly.
    assign vr        = row_rem_q >= RP ? RP : row_rem_q;
    assign vc        = col_rem_q >= CP ? CP : col_rem_q;
    assign row_end   = nt_q == ntc_q - SW'(1);
    assign last_tile = row_end && mt_q == mtc_q - SW'(1);
    assign adv       = state_q == STR && out_ready_i;

    assign sram_c_addr_o = addr_q;
    assign sram_c_re_o   = state_q == RD;
    assign out_valid_o   = state_q == STR;
    assign out_last_o    = out_valid_o && tile_end && last_tile;
    assign busy_o        = state_q != IDLE;
    assign done_o        = state_q == FIN;

    gemm_tile_serializer #(
        .OutDataWidth(OutDataWidth),
        .RowPar      (RowPar),
        .ColPar      (ColPar),
        .LimWidth    (SW)
    ) u_ser (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load_i    (state_q == CAP),
        .tile_i    (sram_c_rdata_i),
        .vr_i      (vr),
        .vc_i      (vc),
        .adv_i     (adv),
        .elem_o    (out_data_o),
        .tile_end_o(tile_end)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        n_d       = n_q;
        mt_d      = mt_q;
        nt_d      = nt_q;
        mtc_d     = mtc_q;
        ntc_d     = ntc_q;
        row_rem_d = row_rem_q;
        col_rem_d = col_rem_q;
        case (state_q)
            IDLE: if (start_i) begin
                n_d       = N_size_i;
                addr_d    = base_addr_i;
                mt_d      = '0;
                nt_d      = '0;
                mtc_d     = SW'(ceil_div(32'(M_size_i), RowPar));
                ntc_d     = SW'(ceil_div(32'(N_size_i), ColPar));
                row_rem_d = M_size_i;
                col_rem_d = N_size_i;
                state_d   = (M_size_i == '0 || N_size_i == '0) ? FIN : RD;
            end
            RD: begin
                addr_d  = addr_q + AddrWidth'(1);
                state_d = CAP;
            end
            CAP: state_d = STR;
            STR: if (adv && tile_end) begin
                state_d   = last_tile ? FIN : RD;
                nt_d      = row_end ? '0 : nt_q + SW'(1);
                mt_d      = row_end ? mt_q + SW'(1) : mt_q;
                row_rem_d = row_end ? row_rem_q - RP : row_rem_q;
                col_rem_d = row_end ? n_q : col_rem_q - CP;
            end
            FIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            n_q       <= '0;
            mt_q      <= '0;
            nt_q      <= '0;
            mtc_q     <= '0;
            ntc_q     <= '0;
            row_rem_q <= '0;
            col_rem_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            n_q       <= n_d;
            mt_q      <= mt_d;
            nt_q      <= nt_d;
            mtc_q     <= mtc_d;
            ntc_q     <= ntc_d;
            row_rem_q <= row_rem_d;
            col_rem_q <= col_rem_d;
        end
    end

endmodule

// File: tb/tb_gemm_result_drain.sv
// tb_gemm_result_drain: directed drains against an SRAM model and a golden C matrix.
module tb_gemm_result_drain;

    localparam int W = 32;
    localparam int R = 4;
    localparam int C = 16;
    localparam int P = R * C;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [7:0]     m_sz = '0;
    logic [7:0]     n_sz = '0;
    logic [15:0]    base = '0;
    logic [15:0]    addr;
    logic           re;
    logic [P*W-1:0] rdata = '0;
    logic [W-1:0]   data;
    logic           valid;
    logic           ready = 1'b1;
    logic           last;
    logic           busy;
    logic           done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [P*W-1:0] mem [logic [15:0]];
    logic [15:0]    reads [$];
    logic [W-1:0]   bd [$];
    logic           bl [$];
    logic [W-1:0]   exp_q [$];
    int             exp_reads;
    int dones, vcyc, stall_err, first_re, first_v, last_cyc, done_cyc, s0;
    bit rnd = 1'b0;
    bit hold = 1'b0;
    logic [W-1:0] hold_d;
    logic         hold_l;

    gemm_result_drain dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .M_size_i      (m_sz),
        .N_size_i      (n_sz),
        .base_addr_i   (base),
        .sram_c_addr_o (addr),
        .sram_c_re_o   (re),
        .sram_c_rdata_i(rdata),
        .out_data_o    (data),
        .out_valid_o   (valid),
        .out_ready_i   (ready),
        .out_last_o    (last),
        .busy_o        (busy),
        .done_o        (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (re) rdata <= mem.exists(addr) ? mem[addr] : '0;
    end

    initial forever begin
        @(posedge clk);
        #1;
        ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        if (hold && (!valid || data !== hold_d || last !== hold_l)) stall_err++;
        hold   = valid && !ready;
        hold_d = data;
        hold_l = last;
        if (re) begin
            reads.push_back(addr);
            if (first_re < 0) first_re = cyc;
        end
        if (valid) begin
            vcyc++;
            if (first_v < 0) first_v = cyc;
        end
        if (valid && ready) begin
            bd.push_back(data);
            bl.push_back(last);
            if (last) last_cyc = cyc;
        end
        if (done) begin
            dones++;
            done_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] gold(input int row, input int col);
        return {4'hA ^ 4'(row + col), 12'(row), 16'(col)};
    endfunction

    task automatic prep(input int m, input int n, input logic [15:0] b);
        int mtn = (m + R - 1) / R;
        int ntn = (n + C - 1) / C;
        logic [P*W-1:0] w;
        mem.delete();
        exp_q.delete();
        exp_reads = mtn * ntn;
        for (int i = 0; i < mtn; i++)
            for (int j = 0; j < ntn; j++) begin
                for (int r = 0; r < R; r++)
                    for (int c = 0; c < C; c++) begin
                        w[(P-1-(r*C+c))*W +: W] = (i*R+r < m && j*C+c < n) ? gold(i*R+r, j*C+c) : 32'hDEAD_BEEF;
                        if (i*R+r < m && j*C+c < n) exp_q.push_back(gold(i*R+r, j*C+c));
                    end
                mem[16'(32'(b) + i*ntn + j)] = w;
            end
        reads.delete();
        bd.delete();
        bl.delete();
        dones = 0; vcyc = 0; stall_err = 0; hold = 1'b0;
        first_re = -1; first_v = -1; last_cyc = -1; done_cyc = -1;
    endtask

    task automatic go(input int m, input int n, input logic [15:0] b);
        @(posedge clk);
        #1;
        m_sz = 8'(m); n_sz = 8'(n); base = b; start = 1'b1; s0 = cyc;
        @(posedge clk);
        #1;
        start = 1'b0; m_sz = '0; n_sz = '0; base = '0;
    endtask

    task automatic run(input string t, input int m, input int n, input logic [15:0] b, input bit rd, input bit mid);
        int k = 0;
        int nl = 0;
        int lp = -1;
        prep(m, n, b);
        rnd = rd;
        go(m, n, b);
        while (dones == 0 && k < 4000) begin
            @(negedge clk);
            k++;
            start = mid && bd.size() == 20;
        end
        start = 1'b0;
        chk({t, "_timeout"}, 64'(k < 4000), 1);
        repeat (4) @(negedge clk);
        rnd = 1'b0;
        chk({t, "_beats"}, bd.size(), exp_q.size());
        for (int i = 0; i < bd.size() && i < exp_q.size(); i++)
            chk($sformatf("%s_data%0d", t, i), bd[i], exp_q[i]);
        foreach (bl[i]) if (bl[i]) begin nl++; lp = i; end
        chk({t, "_lastcnt"}, nl, exp_q.size() > 0 ? 1 : 0);
        chk({t, "_lastpos"}, lp, exp_q.size() - 1);
        chk({t, "_reads"}, reads.size(), exp_reads);
        foreach (reads[i]) chk($sformatf("%s_addr%0d", t, i), reads[i], 16'(32'(b) + i));
        chk({t, "_done"}, dones, 1);
        chk({t, "_busy"}, busy, 0);
        chk({t, "_stall"}, stall_err, 0);
        if (!rd) chk({t, "_vcyc"}, vcyc, exp_q.size());
        if (!rd && exp_q.size() > 0) begin
            chk({t, "_lat_re"}, first_re - s0, 1);
            chk({t, "_lat_v"}, first_v - s0, 3);
            chk({t, "_lat_done"}, done_cyc - last_cyc, 1);
        end
    endtask

    initial begin
        int k = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", {addr, re, data, valid, last, busy, done}, 0);
        rst = 1'b0;
        run("t4x16", 4, 16, 16'h0000, 0, 0);
        run("t6x20", 6, 20, 16'h0010, 0, 0);
        run("t4x16rnd", 4, 16, 16'h0000, 1, 0);
        run("t0x8", 0, 8, 16'h0000, 0, 0);
        prep(8, 16, 16'h0000);
        go(8, 16, 16'h0000);
        while (bd.size() < 70 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk("abort_timeout", 64'(k < 2000), 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_outs", {addr, re, data, valid, last, busy, done}, 0);
        rst = 1'b0;
        dones = 0;
        repeat (10) @(negedge clk);
        chk("abort_nodone", dones, 0);
        chk("abort_idle", busy, 0);
        run("t8x16", 8, 16, 16'h0000, 0, 0);
        run("twrap", 8, 32, 16'hFFFE, 0, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
